// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 shift transmitter.
// Frames are {stop, byte, start}; send enable held until sent or timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FRAME_WIDTH    = 10,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNTR_W         = 32
) (
  input  logic                   hwclk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [2:0]             grant_id,
  output logic                   tx_send_en,
  output logic [FRAME_WIDTH-1:0] tx_data_frame,
  input  logic                   tx_frame_sent,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    GAP
  } state_t;

  state_t                 state_q;
  logic [2:0]             rr_q;
  logic [2:0]             g_q;
  logic [2:0]             gid_q;
  logic [CNTR_W-1:0]      to_cnt_q;
  logic [CNTR_W-1:0]      gap_cnt_q;
  logic                   send_q;
  logic                   busy_q;
  logic                   terr_q;
  logic [FRAME_WIDTH-1:0] frame_q;

  logic                   hit_d;
  logic [2:0]             g_d;
  logic                   gvalid_d;
  logic [7:0]             byte_d;

  function automatic logic [2:0] rr_idx(
    input logic [2:0] base,
    input int         off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 3'(s);
  endfunction

  // Walk downward so the smallest offset from the pointer wins.
  always_comb begin
    hit_d = 1'b0;
    g_d   = rr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[rr_idx(rr_q, i)]) begin
        hit_d = 1'b1;
        g_d   = rr_idx(rr_q, i);
      end
    end
  end

  always_comb begin
    gvalid_d  = 1'b0;
    byte_d    = 8'h00;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == g_q) begin
        gvalid_d     = req_valid[i];
        byte_d       = req_data[8*i +: 8];
        req_ready[i] = (state_q == GRANT) && req_valid[i];
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      g_q       <= '0;
      gid_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      frame_q   <= '1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit_d) begin
            g_q     <= g_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (gvalid_d) begin
            frame_q  <= FRAME_WIDTH'({1'b1, byte_d, 1'b0});
            gid_q    <= g_q;
            rr_q     <= rr_idx(g_q, 1);
            send_q   <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= SEND;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SEND: begin
          if (tx_frame_sent) begin
            send_q    <= 1'b0;
            frame_q   <= '1;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end else if (to_cnt_q == CNTR_W'(TIMEOUT_CYCLES - 1)) begin
            send_q    <= 1'b0;
            frame_q   <= '1;
            terr_q    <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        GAP: begin
          // A zero-length gap still spends one cycle here.
          if ((gap_cnt_q + 1'b1) >= CNTR_W'(GAP_CYCLES)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id      = gid_q;
  assign tx_send_en    = send_q;
  assign tx_data_frame = frame_q;
  assign busy          = busy_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed phases plus randomized
// request traffic checked against a round-robin transaction model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TO  = 50;

  logic           hwclk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [7:0]     bt [N];
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [2:0]     grant_id;
  logic           tx_send_en;
  logic [9:0]     tx_data_frame;
  logic           tx_frame_sent = 1'b0;
  logic           busy;
  logic           timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int mptr  = 0;
  int g;
  int k;

  always #5 hwclk = ~hwclk;

  assign req_data = {bt[3], bt[2], bt[1], bt[0]};

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .FRAME_WIDTH(10),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO),
    .CNTR_W(32)
  ) dut (
    .hwclk(hwclk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .tx_send_en(tx_send_en),
    .tx_data_frame(tx_data_frame),
    .tx_frame_sent(tx_frame_sent),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge hwclk);
  endtask

  // Round-robin rule: first valid requester at or after the pointer.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int j = 0; j < N; j++)
      if (v[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    nedge();
    rst  = 1'b0;
    mptr = 0;
  endtask

  // Called at a negedge in IDLE with valids driven; returns in IDLE.
  task automatic serve(input int dly, input bit drop, output int gg);
    gg = pick(req_valid, mptr);
    if (gg < 0) begin
      chk("pick_empty", 32'(gg), 0);
      gg = 0;
    end
    nedge();
    chk("ready", 32'(req_ready), 32'(1 << gg));
    chk("busy_grant", 32'(busy), 1);
    nedge();
    chk("send_en", 32'(tx_send_en), 1);
    chk("frame", 32'(tx_data_frame), 32'({1'b1, bt[gg], 1'b0}));
    chk("grant_id", 32'(grant_id), 32'(gg));
    chk("ready_off", 32'(req_ready), 0);
    mptr = (gg + 1) % N;
    if (drop) req_valid[gg] = 1'b0;
    for (int j = 1; j < dly; j++) nedge();
    tx_frame_sent = 1'b1;
    nedge();
    chk("send_drop", 32'(tx_send_en), 0);
    chk("frame_idle", 32'(tx_data_frame), 32'h3FF);
    tx_frame_sent = 1'b0;
    for (int j = 0; j < GAP; j++) begin
      chk("busy_gap", 32'(busy), 1);
      nedge();
    end
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) bt[i] = 8'($urandom);
    rst       = 1'b1;
    req_valid = '1;
    repeat (3) begin
      nedge();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_send", 32'(tx_send_en), 0);
      chk("rst_frame", 32'(tx_data_frame), 32'h3FF);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      chk("rst_gid", 32'(grant_id), 0);
    end
    rst       = 1'b0;
    req_valid = '0;
    mptr      = 0;
    nedge();

    bt[2]     = 8'h41;
    req_valid = 4'b0100;
    serve(3, 1'b1, g);

    do_reset();
    for (int i = 0; i < N; i++) bt[i] = 8'(8'h10 + i);
    req_valid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      serve(20, 1'b0, g);
      chk("rr_order", 32'(grant_id), 32'(r % N));
    end
    req_valid = '0;
    nedge();

    bt[0]     = 8'($urandom);
    req_valid = 4'b0001;
    nedge();
    chk("to_ready", 32'(req_ready), 32'h1);
    nedge();
    chk("to_send", 32'(tx_send_en), 1);
    req_valid = '0;
    mptr      = 1;
    k         = 1;
    for (int c = 0; c < 200; c++) begin
      nedge();
      if (!tx_send_en) break;
      k++;
    end
    chk("timeout_len", 32'(k), 32'(TO));
    chk("terr_set", 32'(timeout_err), 1);
    chk("to_frame", 32'(tx_data_frame), 32'h3FF);
    repeat (GAP) nedge();
    chk("to_idle", 32'(busy), 0);
    bt[3]     = 8'($urandom);
    req_valid = 4'b1000;
    serve(4, 1'b1, g);
    chk("terr_sticky", 32'(timeout_err), 1);

    do_reset();
    chk("terr_clr", 32'(timeout_err), 0);
    tx_frame_sent = 1'b1;
    nedge();
    tx_frame_sent = 1'b0;
    chk("idle_sent_busy", 32'(busy), 0);
    chk("idle_sent_en", 32'(tx_send_en), 0);
    bt[1]     = 8'($urandom);
    req_valid = 4'b0010;
    serve(TO, 1'b1, g);
    chk("race_terr", 32'(timeout_err), 0);

    bt[2]     = 8'($urandom);
    req_valid = 4'b0100;
    nedge();
    nedge();
    chk("mid_send", 32'(tx_send_en), 1);
    rst = 1'b1;
    nedge();
    chk("mid_rst_send", 32'(tx_send_en), 0);
    chk("mid_rst_frame", 32'(tx_data_frame), 32'h3FF);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_gid", 32'(grant_id), 0);
    rst       = 1'b0;
    mptr      = 0;
    req_valid = 4'b0011;
    serve(2, 1'b1, g);
    req_valid = '0;
    nedge();
    req_valid = 4'b0010;
    @(posedge hwclk);
    #1 req_valid = '0;
    nedge();
    chk("wd_ready", 32'(req_ready), 0);
    chk("wd_busy", 32'(busy), 1);
    nedge();
    chk("wd_idle", 32'(busy), 0);
    chk("wd_send", 32'(tx_send_en), 0);
    req_valid = 4'b1111;
    serve(2, 1'b0, g);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          bt[i]        = 8'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        k            = int'($urandom_range(0, N - 1));
        bt[k]        = 8'($urandom);
        req_valid[k] = 1'b1;
      end
      serve(int'($urandom_range(1, 6)), 1'b1, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single 8N1 shift transmitter among NUM_REQ byte requesters.
- Accepts one byte per grant over a valid/ready handshake and builds the 10-bit frame (start, 8 data bits LSB first, stop).
- Holds the transmitter's send enable until the frame is reported sent, then enforces an inter-frame gap.
- Sits between on-chip byte sources and the shift transmitter, all in the hwclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- FRAME_WIDTH, 10, frame width in bits; fixed as start + 8 data + stop.
- GAP_CYCLES, 2, idle hwclk cycles after each frame before the next arbitration (0 allowed).
- TIMEOUT_CYCLES, 20000, hwclk cycles in SEND without tx_frame_sent before the frame is aborted.
- CNTR_W, 32, width of the gap and timeout counters.

Ports:
- hwclk  input  1  system clock; one clock for the whole block.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester byte-available flag.
- req_data  input  NUM_REQ*8  requester i's byte is bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot, single-cycle accept pulse.
- grant_id  output  3  index of the last granted requester.
- tx_send_en  output  1  send enable to the shift transmitter.
- tx_data_frame  output  FRAME_WIDTH  frame to the transmitter; bit 0 is shifted first.
- tx_frame_sent  input  1  single-hwclk pulse when the transmitter has finished the frame; synchronised to hwclk at integration.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky flag; set on abort, cleared only by rst.

Behaviour:
- Reset values (all take effect at the first hwclk edge with rst=1):
  - state IDLE; rr pointer 0; grant_id 0.
  - req_ready 0; tx_send_en 0; busy 0; timeout_err 0.
  - tx_data_frame all ones (idle line); counters 0.
- States: IDLE, GRANT, SEND, GAP.
- IDLE:
  - Search req_valid starting at the rr pointer, wrapping modulo NUM_REQ.
  - On the first hit g: register g and go to GRANT.
  - No valid requesters: remain in IDLE.
- GRANT (one cycle):
  - If req_valid[g]=1: req_ready[g]=1 for this cycle only.
  - Capture req_data[g] and set tx_data_frame = {1'b1, byte, 1'b0}.
  - Set grant_id=g and rr pointer=(g+1) mod NUM_REQ, then go to SEND.
  - If req_valid[g]=0 (requester withdrew): no ready pulse, pointer unchanged, return to IDLE.
- SEND:
  - tx_send_en=1; tx_data_frame held stable; timeout counter increments every cycle.
  - tx_frame_sent=1: drop tx_send_en at the next edge and go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_frame_sent: drop tx_send_en, set timeout_err, go to GAP.
  - tx_frame_sent and timeout in the same cycle: tx_frame_sent wins and timeout_err is not set.
- GAP:
  - tx_send_en=0 and tx_data_frame returns to all ones.
  - Count GAP_CYCLES, then go to IDLE. GAP_CYCLES=0 means GAP lasts one cycle.
- Latency: req_valid first seen in IDLE at cycle N -> req_ready at N+1 -> tx_send_en high at N+2.
- Handshake rules:
  - Requesters hold valid and data stable until ready; transfer occurs on valid & ready.
  - Non-granted requesters never see ready.
  - At most one req_ready bit is high in any cycle.
- tx_frame_sent in IDLE, GRANT or GAP is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- NUM_REQ=1: pointer stays 0.
- Reset mid-operation (any state): all outputs return to reset values at that edge, and the captured byte is discarded.

Test Plan:
- rst high 3 cycles with req_valid=4'b1111 -> req_ready=0, tx_send_en=0, tx_data_frame=10'h3FF, busy=0.
- Single request, req_valid[2]=1, req_data byte2=8'h41 -> req_ready=4'b0100 one cycle later; two cycles after valid, tx_send_en=1 with tx_data_frame=10'b1010000010; pulse tx_frame_sent -> tx_send_en=0 next edge; busy falls after 2 gap cycles.
- All four valid continuously, bytes 8'h10/8'h11/8'h12/8'h13, tx_frame_sent pulsed 20 cycles after each send_en rise -> grant order 0,1,2,3,0; each frame = {1,byte,0}; ready never multi-hot.
- No tx_frame_sent with TIMEOUT_CYCLES=50 -> tx_send_en drops after exactly 50 SEND cycles, timeout_err=1 and stays 1; next request is still served.
- tx_frame_sent on the final timeout cycle -> timeout_err stays 0; tx_frame_sent in IDLE -> no state change.
- rst asserted in SEND, and req_valid[1] withdrawn during GRANT -> send_en=0 next edge with pointer 0; withdrawal yields no ready, return to IDLE, pointer unchanged.
